// File: rtl/demux_bit_sequencer_if.sv
// Byte-in / serial-bit-out bundle for demux_bit_sequencer.
// master drives bytes and abort; slave is the sequencer producing demux bits.
interface demux_bit_sequencer_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       abort;
    logic       d00;
    logic [2:0] s;
    logic       bit_valid;
    logic       busy;
    logic       frame_done;

    modport master (
        output in_data,
        output in_valid,
        output abort,
        input  in_ready,
        input  d00,
        input  s,
        input  bit_valid,
        input  busy,
        input  frame_done
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  abort,
        output in_ready,
        output d00,
        output s,
        output bit_valid,
        output busy,
        output frame_done
    );
endinterface

// File: rtl/demux_bit_sequencer.sv
// Serialises one byte per frame onto d00 with its bit index on s, steering a 1:8 demux.
// Outputs are registered from next-state values so they line up with the FSM state.
module demux_bit_sequencer #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demux_bit_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [2:0] FIRST_IDX = MSB_FIRST ? 3'd7 : 3'd0;
    localparam logic [2:0] LAST_IDX  = MSB_FIRST ? 3'd0 : 3'd7;

    function automatic logic [2:0] step_idx(input logic [2:0] idx);
        if (MSB_FIRST) begin
            return idx - 3'd1;
        end else begin
            return idx + 3'd1;
        end
    endfunction

    state_t     state_r;
    state_t     state_nxt_s;
    logic [7:0] shadow_r;
    logic [7:0] shadow_nxt_s;
    logic [2:0] idx_r;
    logic [2:0] idx_nxt_s;
    logic       in_ready_s;
    logic       accept_s;
    logic       shift_nxt_s;
    logic       d00_nxt_s;
    logic [2:0] s_nxt_s;
    logic       d00_r;
    logic [2:0] s_r;
    logic       bit_valid_r;
    logic       busy_r;
    logic       frame_done_r;

    // Ready is decoded from state only, so no input reaches it combinationally.
    assign in_ready_s = (state_r != ST_SHIFT);
    assign accept_s   = bus.in_valid && in_ready_s;

    // Next-state, bit index and shadow byte selection.
    always_comb begin
        state_nxt_s  = state_r;
        idx_nxt_s    = idx_r;
        shadow_nxt_s = shadow_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    state_nxt_s  = ST_SHIFT;
                    idx_nxt_s    = FIRST_IDX;
                    shadow_nxt_s = bus.in_data;
                end else begin
                    state_nxt_s  = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // Abort outranks the final bit: the frame ends without a done pulse.
                if (bus.abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (idx_r == LAST_IDX) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    idx_nxt_s   = step_idx(idx_r);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, forced to zero outside SHIFT.
    always_comb begin
        shift_nxt_s = (state_nxt_s == ST_SHIFT);
        d00_nxt_s   = 1'b0;
        s_nxt_s     = 3'd0;
        if (shift_nxt_s) begin
            d00_nxt_s = shadow_nxt_s[idx_nxt_s];
            s_nxt_s   = idx_nxt_s;
        end else begin
            d00_nxt_s = 1'b0;
            s_nxt_s   = 3'd0;
        end
    end

    // FSM state, shadow byte and bit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            shadow_r <= 8'h00;
            idx_r    <= 3'd0;
        end else begin
            state_r  <= state_nxt_s;
            shadow_r <= shadow_nxt_s;
            idx_r    <= idx_nxt_s;
        end
    end

    // Registered demux-facing outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d00_r        <= 1'b0;
            s_r          <= 3'd0;
            bit_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            d00_r        <= d00_nxt_s;
            s_r          <= s_nxt_s;
            bit_valid_r  <= shift_nxt_s;
            busy_r       <= shift_nxt_s;
            frame_done_r <= (state_nxt_s == ST_DONE);
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.d00        = d00_r;
    assign bus.s          = s_r;
    assign bus.bit_valid  = bit_valid_r;
    assign bus.busy       = busy_r;
    assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_demux_bit_sequencer.sv
// Directed bench: an LSB-first and an MSB-first sequencer share stimulus and are
// checked against hand-written per-frame bit sequences.
module tb_demux_bit_sequencer;

    typedef struct {
        logic [7:0] data;
        logic [7:0] seq_l;      // bit k = d00 in k-th SHIFT cycle, LSB-first
        logic [7:0] seq_m;      // bit k = d00 in k-th SHIFT cycle, MSB-first
        int         abort_at;   // SHIFT cycle where abort is raised, 8 = never
        logic       noise;      // hold in_valid with noise_data during SHIFT
        logic [7:0] noise_data;
        logic       b2b;        // next record's byte is offered in DONE
        logic       abort_acc;  // abort raised together with acceptance
    } rec_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    demux_bit_sequencer_if bus_l ();
    demux_bit_sequencer_if bus_m ();

    demux_bit_sequencer #(.MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst_n(rst_n), .bus(bus_l));
    demux_bit_sequencer #(.MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst_n(rst_n), .bus(bus_m));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic a);
        bus_l.in_valid = v; bus_l.in_data = d; bus_l.abort = a;
        bus_m.in_valid = v; bus_m.in_data = d; bus_m.abort = a;
    endtask

    // Outputs expected outside SHIFT (IDLE, DONE, reset).
    task automatic chk_quiet(input string tag, input logic done);
        chk({tag, " bit_valid_l"}, bus_l.bit_valid, 8'd0);
        chk({tag, " bit_valid_m"}, bus_m.bit_valid, 8'd0);
        chk({tag, " busy_l"}, bus_l.busy, 8'd0);
        chk({tag, " busy_m"}, bus_m.busy, 8'd0);
        chk({tag, " d00_l"}, bus_l.d00, 8'd0);
        chk({tag, " d00_m"}, bus_m.d00, 8'd0);
        chk({tag, " s_l"}, bus_l.s, 8'd0);
        chk({tag, " s_m"}, bus_m.s, 8'd0);
        chk({tag, " frame_done_l"}, bus_l.frame_done, done);
        chk({tag, " frame_done_m"}, bus_m.frame_done, done);
        chk({tag, " in_ready_l"}, bus_l.in_ready, 8'd1);
        chk({tag, " in_ready_m"}, bus_m.in_ready, 8'd1);
    endtask

    task automatic chk_bit(input int k, input logic [7:0] seq_l, input logic [7:0] seq_m);
        chk($sformatf("shift%0d bit_valid_l", k), bus_l.bit_valid, 8'd1);
        chk($sformatf("shift%0d bit_valid_m", k), bus_m.bit_valid, 8'd1);
        chk($sformatf("shift%0d busy_l", k), bus_l.busy, 8'd1);
        chk($sformatf("shift%0d busy_m", k), bus_m.busy, 8'd1);
        chk($sformatf("shift%0d in_ready_l", k), bus_l.in_ready, 8'd0);
        chk($sformatf("shift%0d in_ready_m", k), bus_m.in_ready, 8'd0);
        chk($sformatf("shift%0d frame_done_l", k), bus_l.frame_done, 8'd0);
        chk($sformatf("shift%0d frame_done_m", k), bus_m.frame_done, 8'd0);
        chk($sformatf("shift%0d s_l", k), bus_l.s, 8'(k));
        chk($sformatf("shift%0d s_m", k), bus_m.s, 8'(7 - k));
        chk($sformatf("shift%0d d00_l", k), bus_l.d00, seq_l[k]);
        chk($sformatf("shift%0d d00_m", k), bus_m.d00, seq_m[k]);
    endtask

    // One frame; carry means the byte was already offered in the previous DONE.
    task automatic run_frame(input rec_t r, input bit carry, input rec_t nxt, output bit carry_out);
        bit aborted;
        aborted   = 1'b0;
        carry_out = 1'b0;
        if (!carry) begin
            @(negedge clk);
            chk_quiet("idle", 1'b0);
            drive(1'b1, r.data, r.abort_acc);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk_bit(k, r.seq_l, r.seq_m);
            drive(r.noise, r.noise_data, (r.abort_at == k));
            if (r.abort_at == k) begin
                @(negedge clk);
                chk_quiet("after_abort", 1'b0);
                drive(1'b0, 8'h00, 1'b0);
                aborted = 1'b1;
                break;
            end
        end
        if (!aborted) begin
            @(negedge clk);
            chk_quiet("done", 1'b1);
            if (r.b2b) begin
                drive(1'b1, nxt.data, nxt.abort_acc);
                carry_out = 1'b1;
            end else begin
                drive(1'b0, 8'h00, 1'b0);
            end
        end
    endtask

    rec_t tbl [0:8];
    rec_t rec01;
    bit   carry;
    bit   carry_o;

    initial begin
        tests = 0;
        fails = 0;
        tbl[0] = '{data:8'hA5, seq_l:8'hA5, seq_m:8'hA5, abort_at:8, noise:1'b0, noise_data:8'h00, b2b:1'b0, abort_acc:1'b1};
        tbl[1] = '{data:8'h2D, seq_l:8'h2D, seq_m:8'hB4, abort_at:8, noise:1'b0, noise_data:8'h00, b2b:1'b0, abort_acc:1'b0};
        tbl[2] = '{data:8'hFF, seq_l:8'hFF, seq_m:8'hFF, abort_at:8, noise:1'b0, noise_data:8'h00, b2b:1'b1, abort_acc:1'b0};
        tbl[3] = '{data:8'h00, seq_l:8'h00, seq_m:8'h00, abort_at:8, noise:1'b0, noise_data:8'h00, b2b:1'b0, abort_acc:1'b1};
        tbl[4] = '{data:8'hF0, seq_l:8'hF0, seq_m:8'h0F, abort_at:8, noise:1'b1, noise_data:8'h3C, b2b:1'b1, abort_acc:1'b0};
        tbl[5] = '{data:8'h3C, seq_l:8'h3C, seq_m:8'h3C, abort_at:8, noise:1'b0, noise_data:8'h00, b2b:1'b0, abort_acc:1'b0};
        tbl[6] = '{data:8'hFF, seq_l:8'hFF, seq_m:8'hFF, abort_at:3, noise:1'b0, noise_data:8'h00, b2b:1'b0, abort_acc:1'b0};
        tbl[7] = '{data:8'h81, seq_l:8'h81, seq_m:8'h81, abort_at:7, noise:1'b0, noise_data:8'h00, b2b:1'b0, abort_acc:1'b0};
        tbl[8] = '{data:8'h81, seq_l:8'h81, seq_m:8'h81, abort_at:8, noise:1'b0, noise_data:8'h00, b2b:1'b0, abort_acc:1'b0};
        rec01  = '{data:8'h01, seq_l:8'h01, seq_m:8'h80, abort_at:8, noise:1'b0, noise_data:8'h00, b2b:1'b0, abort_acc:1'b0};

        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        chk_quiet("reset", 1'b0);
        rst_n = 1'b1;

        carry = 1'b0;
        for (int i = 0; i < 9; i++) begin
            run_frame(tbl[i], carry, (i < 8) ? tbl[i + 1] : tbl[i], carry_o);
            carry = carry_o;
        end

        // Reset asserted while bit 5 of 8'hA5 is on the outputs.
        @(negedge clk);
        chk_quiet("pre_rst_idle", 1'b0);
        drive(1'b1, 8'hA5, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk_bit(k, 8'hA5, 8'hA5);
            drive(1'b0, 8'h00, 1'b0);
        end
        #1 rst_n = 1'b0;
        #1 chk_quiet("async_rst", 1'b0);
        @(negedge clk);
        chk_quiet("rst_held", 1'b0);
        rst_n = 1'b1;
        drive(1'b1, 8'h01, 1'b0);
        run_frame(rec01, 1'b1, rec01, carry_o);
        @(negedge clk);
        chk_quiet("final_idle", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
